// File: rtl/ps2_guess_input.sv
// PS/2 keyboard front end for hangman: receives set-2 scan codes and turns each
// newly pressed letter key into a one-cycle guess pulse (or a repeat-guess pulse).
module ps2_guess_input #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_dat,
    input  logic        enable,
    input  logic [25:0] guessed_mask,
    output logic        load,
    output logic [4:0]  load_x,
    output logic        repeat_guess,
    output logic        frame_err
);
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {ST_MAKE, ST_BRK, ST_EXT, ST_EXT_BRK} state_t;

    logic [1:0]    r_clk_sync;
    logic [1:0]    r_dat_sync;
    logic          r_clk_prev;
    logic [3:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_parity;
    logic [IW-1:0] r_idle;
    logic          r_byte_valid;
    logic [7:0]    r_byte;
    logic          r_frame_err;

    state_t        r_state;
    logic [7:0]    r_held;
    logic          r_load;
    logic [4:0]    r_load_x;
    logic          r_repeat;

    logic          w_fall;
    logic          w_dat;
    logic          w_is_letter;
    logic [4:0]    w_idx;

    // Synchronizers reset to the idle-high line level so reset never fakes an edge.
    assign w_fall = r_clk_prev & ~r_clk_sync[1];
    assign w_dat  = r_dat_sync[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_sync   <= 2'b11;
            r_dat_sync   <= 2'b11;
            r_clk_prev   <= 1'b1;
            r_bit_cnt    <= 4'd0;
            r_shift      <= 8'd0;
            r_parity     <= 1'b0;
            r_idle       <= '0;
            r_byte_valid <= 1'b0;
            r_byte       <= 8'd0;
            r_frame_err  <= 1'b0;
        end else begin
            r_clk_sync   <= {r_clk_sync[0], ps2_clk};
            r_dat_sync   <= {r_dat_sync[0], ps2_dat};
            r_clk_prev   <= r_clk_sync[1];
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            if (w_fall) begin
                r_idle <= '0;
                case (r_bit_cnt)
                    4'd0: if (!w_dat) r_bit_cnt <= 4'd1;
                    4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
                        r_shift   <= {w_dat, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end
                    4'd9: begin
                        r_parity  <= w_dat;
                        r_bit_cnt <= 4'd10;
                    end
                    default: begin
                        r_bit_cnt <= 4'd0;
                        if ((^{r_shift, r_parity}) && w_dat) begin
                            r_byte       <= r_shift;
                            r_byte_valid <= 1'b1;
                        end else begin
                            r_frame_err  <= 1'b1;
                        end
                    end
                endcase
            end else if (r_bit_cnt != 4'd0) begin
                if (r_idle == IW'(TIMEOUT_CYCLES - 1)) begin
                    r_bit_cnt   <= 4'd0;
                    r_idle      <= '0;
                    r_frame_err <= 1'b1;
                end else begin
                    r_idle <= r_idle + IW'(1);
                end
            end
        end
    end

    always_comb begin
        w_is_letter = 1'b1;
        w_idx       = 5'd0;
        case (r_byte)
            8'h1C: w_idx = 5'd0;   8'h32: w_idx = 5'd1;   8'h21: w_idx = 5'd2;
            8'h23: w_idx = 5'd3;   8'h24: w_idx = 5'd4;   8'h2B: w_idx = 5'd5;
            8'h34: w_idx = 5'd6;   8'h33: w_idx = 5'd7;   8'h43: w_idx = 5'd8;
            8'h3B: w_idx = 5'd9;   8'h42: w_idx = 5'd10;  8'h4B: w_idx = 5'd11;
            8'h3A: w_idx = 5'd12;  8'h31: w_idx = 5'd13;  8'h44: w_idx = 5'd14;
            8'h4D: w_idx = 5'd15;  8'h15: w_idx = 5'd16;  8'h2D: w_idx = 5'd17;
            8'h1B: w_idx = 5'd18;  8'h2C: w_idx = 5'd19;  8'h3C: w_idx = 5'd20;
            8'h2A: w_idx = 5'd21;  8'h1D: w_idx = 5'd22;  8'h22: w_idx = 5'd23;
            8'h35: w_idx = 5'd24;  8'h1A: w_idx = 5'd25;
            default: w_is_letter = 1'b0;
        endcase
    end

    // held == 0 means no letter key is down; 0x00 is never a letter code.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_MAKE;
            r_held   <= 8'd0;
            r_load   <= 1'b0;
            r_load_x <= 5'd0;
            r_repeat <= 1'b0;
        end else begin
            r_load   <= 1'b0;
            r_repeat <= 1'b0;
            if (r_byte_valid) begin
                case (r_state)
                    ST_MAKE: begin
                        if (r_byte == 8'hF0) begin
                            r_state <= ST_BRK;
                        end else if (r_byte == 8'hE0) begin
                            r_state <= ST_EXT;
                        end else if (w_is_letter && (r_byte != r_held)) begin
                            r_held <= r_byte;
                            if (enable) begin
                                if (guessed_mask[w_idx]) begin
                                    r_repeat <= 1'b1;
                                end else begin
                                    r_load   <= 1'b1;
                                    r_load_x <= w_idx;
                                end
                            end
                        end
                    end
                    ST_BRK: begin
                        r_state <= ST_MAKE;
                        if (r_byte == r_held) r_held <= 8'd0;
                    end
                    ST_EXT:  r_state <= (r_byte == 8'hF0) ? ST_EXT_BRK : ST_MAKE;
                    default: r_state <= ST_MAKE;
                endcase
            end
        end
    end

    assign load         = r_load;
    assign load_x       = r_load_x;
    assign repeat_guess = r_repeat;
    assign frame_err    = r_frame_err;
endmodule

// File: tb/tb_ps2_guess_input.sv
// Directed bench for ps2_guess_input: bit-bangs PS/2 frames and checks the guess,
// repeat and frame-error pulses against hand-computed expectations.
module tb_ps2_guess_input;
    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic        ps2_clk;
    logic        ps2_dat;
    logic        enable;
    logic [25:0] guessed_mask;
    logic        load;
    logic [4:0]  load_x;
    logic        repeat_guess;
    logic        frame_err;

    int errors = 0;
    int checks = 0;
    int n_load = 0;
    int n_rep  = 0;
    int n_ferr = 0;
    logic [4:0] exp_q[$];

    always #5 clk = ~clk;

    ps2_guess_input #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .enable(enable), .guessed_mask(guessed_mask), .load(load), .load_x(load_x),
        .repeat_guess(repeat_guess), .frame_err(frame_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse monitor and load scoreboard, sampled away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (load) begin
                n_load++;
                check("load_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) check("load_x", 32'(load_x), 32'(exp_q.pop_front()));
            end
            if (repeat_guess) n_rep++;
            if (frame_err) n_ferr++;
            if (load || repeat_guess || frame_err)
                check("pulse_exclusive", 32'(load) + 32'(repeat_guess) + 32'(frame_err), 32'd1);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        tick(2);
        ps2_clk = 1'b0;
        tick(4);
        ps2_clk = 1'b1;
        tick(4);
    endtask

    // Start, data LSB first and parity; the stop bit is left to the caller.
    task automatic send_head(input logic [7:0] d, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit((~^d) ^ bad_par);
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_head(d, 1'b0);
        ps2_bit(1'b1);
        tick(4);
    endtask

    int l0, r0, f0;

    initial begin
        reset = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1; enable = 1'b0; guessed_mask = '0;
        tick(5);
        check("reset_load", 32'(load), 32'd0);
        check("reset_load_x", 32'(load_x), 32'd0);
        check("reset_repeat", 32'(repeat_guess), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        reset = 1'b0;
        enable = 1'b1;
        tick(3);

        // Make 0x1C: load lands exactly two cycles after the stop-bit edge.
        exp_q.push_back(5'd0);
        send_head(8'h1C, 1'b0);
        ps2_dat = 1'b1;
        tick(2);
        ps2_clk = 1'b0;
        tick(3);
        check("a_load_at_n1", 32'(load), 32'd0);
        tick(1);
        check("a_load_at_n2", 32'(load), 32'd1);
        check("a_load_x_at_n2", 32'(load_x), 32'd0);
        tick(1);
        check("a_load_one_cycle", 32'(load), 32'd0);
        check("a_load_x_held", 32'(load_x), 32'd0);
        ps2_clk = 1'b1;
        tick(6);
        check("a_load_count", 32'(n_load), 32'd1);

        // Typematic repeats suppressed until the key is released.
        l0 = n_load;
        exp_q.push_back(5'd25);
        exp_q.push_back(5'd25);
        send_byte(8'h1A); send_byte(8'h1A); send_byte(8'h1A);
        send_byte(8'hF0); send_byte(8'h1A);
        send_byte(8'h1A);
        check("z_two_loads", 32'(n_load - l0), 32'd2);
        check("z_queue_drained", 32'(exp_q.size()), 32'd0);

        // Already-guessed letter reports a repeat instead of a load.
        l0 = n_load; r0 = n_rep;
        guessed_mask = 26'h0000010;
        send_byte(8'h24);
        check("e_repeat_pulse", 32'(n_rep - r0), 32'd1);
        check("e_no_load", 32'(n_load - l0), 32'd0);
        guessed_mask = '0;

        // Extended make/break never produce guesses; FSM returns to MAKE.
        l0 = n_load;
        send_byte(8'hE0); send_byte(8'h1C);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h1C);
        check("ext_no_load", 32'(n_load - l0), 32'd0);
        exp_q.push_back(5'd0);
        send_byte(8'h1C);
        check("ext_then_a", 32'(n_load - l0), 32'd1);

        // Even-parity frame: frame_err at N+1, byte dropped.
        l0 = n_load; f0 = n_ferr;
        send_head(8'h2C, 1'b1);
        ps2_dat = 1'b1;
        tick(2);
        ps2_clk = 1'b0;
        tick(3);
        check("par_err_at_n1", 32'(frame_err), 32'd1);
        tick(1);
        check("par_err_one_cycle", 32'(frame_err), 32'd0);
        ps2_clk = 1'b1;
        tick(6);
        check("par_err_count", 32'(n_ferr - f0), 32'd1);
        check("par_no_load", 32'(n_load - l0), 32'd0);

        // Abandoned frame after 5 bits times out after TO idle cycles.
        f0 = n_ferr;
        ps2_bit(1'b0); ps2_bit(1'b0); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
        tick(80);
        check("timeout_not_early", 32'(n_ferr - f0), 32'd0);
        tick(40);
        check("timeout_err", 32'(n_ferr - f0), 32'd1);
        exp_q.push_back(5'd19);
        l0 = n_load;
        send_byte(8'h2C);
        check("t_after_timeout", 32'(n_load - l0), 32'd1);

        // Disabled: no pulses, but held still tracks the key.
        enable = 1'b0;
        l0 = n_load; r0 = n_rep; f0 = n_ferr;
        send_byte(8'h33);
        check("dis_no_load", 32'(n_load - l0), 32'd0);
        check("dis_no_repeat", 32'(n_rep - r0), 32'd0);
        enable = 1'b1;
        send_byte(8'h33);
        check("held_suppress", 32'(n_load - l0), 32'd0);
        exp_q.push_back(5'd7);
        send_byte(8'hF0); send_byte(8'h33);
        send_byte(8'h33);
        check("h_after_release", 32'(n_load - l0), 32'd1);
        check("h_load_x_held", 32'(load_x), 32'd7);

        // Reset mid-frame: outputs cleared, partial frame silently discarded.
        f0 = n_ferr;
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
        reset = 1'b1;
        tick(3);
        check("mid_reset_load_x", 32'(load_x), 32'd0);
        check("mid_reset_outputs", {29'd0, load, repeat_guess, frame_err}, 32'd0);
        reset = 1'b0;
        tick(150);
        check("mid_reset_no_err", 32'(n_ferr - f0), 32'd0);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
